imem_boot_loader: RTL

- Upstream stage of the single-cycle RV32I core.
- Receives a program as a byte stream from a host-side byte source (UART RX or testbench driver) and assembles little-endian 32-bit words.
- Writes those words into the instruction memory through its write port.
- Holds the core in reset until the image is fully loaded and the checksum matches. After that, the core fetches from PC 0 out of a freshly loaded IMEM.

---
 rtl/imem_boot_loader.sv | 118 +++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into IMEM and holds the core in reset until it verifies.
// Latency: one cycle from the 4th byte of a word to its write strobe; rx_ready drops in WRAP/DONE/ERR.
module imem_boot_loader #(
  parameter int MAX_WORDS = 1024,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  output logic             imem_we,
  output logic [31:0]      imem_waddr,
  output logic [31:0]      imem_wdata,
  output logic             core_rst_n,
  output logic             load_done,
  output logic             load_err,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic [2:0] {HDR, LOAD, WRAP, CHK, DONE, ERR} state_t;

  state_t      state, next_state;
  logic [1:0]  byte_idx;
  logic [31:0] hdr_n;
  logic [31:0] word_reg;
  logic [7:0]  xor_acc;

  logic        accept;
  logic        last_byte;
  logic        last_word;
  logic [31:0] n_full;
  logic        ready_nxt;
  logic        done_nxt;
  logic        err_nxt;

  assign accept    = rx_valid && rx_ready;
  assign last_byte = (byte_idx == 2'd3);
  assign n_full    = {rx_data, hdr_n[23:0]};
  assign last_word = ((32'(word_count) + 32'd1) == hdr_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HDR;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      HDR: begin
        if (accept && last_byte) begin
          if (n_full > 32'(MAX_WORDS)) next_state = ERR;
          else if (n_full == 32'd0)    next_state = CHK;
          else                         next_state = LOAD;
        end
      end
      LOAD:    if (accept && last_byte && last_word) next_state = WRAP;
      // WRAP covers the final write strobe; the checksum byte is taken afterwards.
      WRAP:    next_state = CHK;
      CHK:     if (accept) next_state = (rx_data == xor_acc) ? DONE : ERR;
      DONE:    next_state = DONE;
      ERR:     next_state = ERR;
      default: next_state = HDR;
    endcase
  end

  always_comb begin
    ready_nxt = (next_state == HDR) || (next_state == LOAD) || (next_state == CHK);
    done_nxt  = (next_state == DONE);
    err_nxt   = (next_state == ERR);
  end

  // Status outputs are registered from next_state so they track state without a reset-time glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ready   <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      rx_ready   <= ready_nxt;
      load_done  <= done_nxt;
      load_err   <= err_nxt;
      core_rst_n <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx   <= 2'd0;
      hdr_n      <= 32'd0;
      word_reg   <= 32'd0;
      xor_acc    <= 8'd0;
      word_count <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= 32'd0;
      imem_wdata <= 32'd0;
    end else begin
      imem_we <= 1'b0;
      if (accept && state == HDR) begin
        hdr_n[8*byte_idx +: 8] <= rx_data;
        byte_idx               <= byte_idx + 2'd1;
      end
      if (accept && state == LOAD) begin
        word_reg[8*byte_idx +: 8] <= rx_data;
        xor_acc                   <= xor_acc ^ rx_data;
        byte_idx                  <= byte_idx + 2'd1;
        if (last_byte) begin
          imem_we    <= 1'b1;
          imem_wdata <= {rx_data, word_reg[23:0]};
          imem_waddr <= 32'({word_count, 2'b00});
          word_count <= word_count + CNT_W'(1);
        end
      end
    end
  end

endmodule
